// File: rtl/mem_rsp_pkg.sv
// rtl/mem_rsp_pkg.sv - shared opcodes, FSM states and request record for the line responder
package mem_rsp_pkg;

  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_CL_BITS = 128;
  localparam int MEM_TAG_W   = 2;

  localparam logic [4:0] MEM_LD_LINE = 5'd4;
  localparam logic [4:0] MEM_ST_LINE = 5'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0]  addr;
    logic [MEM_CL_BITS-1:0] data;
    logic [MEM_TAG_W-1:0]   tag;
    logic [4:0]             opcode;
    logic                   insn;
  } mem_req_t;

endpackage

// File: rtl/mem_line_ram.sv
// rtl/mem_line_ram.sv - single-port line-wide RAM with a registered, enable-held read port
module mem_line_ram #(
  parameter int WIDTH    = 128,
  parameter int LG_DEPTH = 12
) (
  input  logic                clk,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [LG_DEPTH-1:0] addr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  output logic [WIDTH-1:0]    rdata_o
);

  logic [WIDTH-1:0] mem_q [2**LG_DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read data holds until the next read so the owner may sample it later.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - memory-side line port: one request at a time, fixed-latency response
module mem_line_responder
  import mem_rsp_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CL_BITS     = 128,
  parameter int LG_CL_BYTES = 4,
  parameter int TAG_W       = 2,
  parameter int LG_LINES    = 12,
  parameter int LATENCY     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_req_valid,
  input  logic [ADDR_W-1:0]  mem_req_addr,
  input  logic [CL_BITS-1:0] mem_req_store_data,
  input  logic [TAG_W-1:0]   mem_req_tag,
  input  logic [4:0]         mem_req_opcode,
  input  logic               mem_req_insn,
  output logic               mem_req_ack,
  output logic               mem_rsp_valid,
  output logic [CL_BITS-1:0] mem_rsp_load_data,
  output logic [TAG_W-1:0]   mem_rsp_tag,
  output logic [4:0]         mem_rsp_opcode,
  output logic               busy,
  output logic [31:0]        num_loads,
  output logic [31:0]        num_stores,
  output logic [31:0]        num_errors
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("mem_line_responder: LATENCY must be 1..255");
  end
  if (LG_CL_BYTES != $clog2(CL_BITS / 8)) begin : g_bad_line
    $error("mem_line_responder: LG_CL_BYTES does not match CL_BITS");
  end
  if (ADDR_W != MEM_ADDR_W || CL_BITS != MEM_CL_BITS || TAG_W != MEM_TAG_W) begin : g_bad_width
    $error("mem_line_responder: port widths differ from the shared request record");
  end

  localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

  state_t       state_q, state_d;
  mem_req_t     req_q, req_d;
  logic [7:0]   lat_cnt_q, lat_cnt_d;
  logic         ack_q, ack_d;
  logic [31:0]  num_loads_q, num_loads_d;
  logic [31:0]  num_stores_q, num_stores_d;
  logic [31:0]  num_errors_q, num_errors_d;

  logic                ram_en, ram_we;
  logic [LG_LINES-1:0] ram_addr, in_idx, req_idx;
  logic [CL_BITS-1:0]  ram_rdata;
  logic                req_is_load, req_is_store, in_is_load;

  assign in_idx       = mem_req_addr[LG_CL_BYTES +: LG_LINES];
  assign req_idx      = req_q.addr[LG_CL_BYTES +: LG_LINES];
  assign in_is_load   = (mem_req_opcode == MEM_LD_LINE);
  assign req_is_load  = (req_q.opcode == MEM_LD_LINE);
  assign req_is_store = (req_q.opcode == MEM_ST_LINE) && !req_q.insn;

  // Line offset and aliasing upper address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr[ADDR_W-1:LG_CL_BYTES+LG_LINES],
                              mem_req_addr[LG_CL_BYTES-1:0],
                              req_q.addr[ADDR_W-1:LG_CL_BYTES+LG_LINES],
                              req_q.addr[LG_CL_BYTES-1:0]};

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    lat_cnt_d    = lat_cnt_q;
    ack_d        = 1'b0;
    num_loads_d  = num_loads_q;
    num_stores_d = num_stores_q;
    num_errors_d = num_errors_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = req_idx;

    case (state_q)
      IDLE: begin
        if (mem_req_valid) begin
          req_d.addr   = mem_req_addr;
          req_d.data   = mem_req_store_data;
          req_d.tag    = mem_req_tag;
          req_d.opcode = mem_req_opcode;
          req_d.insn   = mem_req_insn;
          lat_cnt_d    = LAT_INIT;
          ack_d        = 1'b1;
          state_d      = BUSY;
          // With a single BUSY cycle the read must start now to land by RESP.
          if (LATENCY == 1 && in_is_load) begin
            ram_en   = 1'b1;
            ram_addr = in_idx;
          end
        end
      end
      BUSY: begin
        if (lat_cnt_q == 8'd0) begin
          state_d = RESP;
          if (req_is_store) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
          if (lat_cnt_q == 8'd1 && req_is_load) begin
            ram_en = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (req_is_load) begin
          num_loads_d = num_loads_q + 32'd1;
        end else if (req_is_store) begin
          num_stores_d = num_stores_q + 32'd1;
        end else begin
          num_errors_d = num_errors_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An abandoned request must never reach the RAM.
    if (!reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      lat_cnt_q    <= '0;
      ack_q        <= 1'b0;
      num_loads_q  <= '0;
      num_stores_q <= '0;
      num_errors_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      lat_cnt_q    <= lat_cnt_d;
      ack_q        <= ack_d;
      num_loads_q  <= num_loads_d;
      num_stores_q <= num_stores_d;
      num_errors_q <= num_errors_d;
    end
  end

  mem_line_ram #(
    .WIDTH   (CL_BITS),
    .LG_DEPTH(LG_LINES)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(req_q.data),
    .rdata_o(ram_rdata)
  );

  assign mem_req_ack       = ack_q;
  assign mem_rsp_valid     = (state_q == RESP);
  assign mem_rsp_load_data = (state_q == RESP && req_is_load) ? ram_rdata : '0;
  assign mem_rsp_tag       = req_q.tag;
  assign mem_rsp_opcode    = req_q.opcode;
  assign busy              = (state_q != IDLE);
  assign num_loads         = num_loads_q;
  assign num_stores        = num_stores_q;
  assign num_errors        = num_errors_q;

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side end of the core's cache-line memory port.
- Accepts one line request at a time from the L1D/L1I arbiter: valid held until response; tag, opcode and insn flag travel with it.
- Services the request against an internal line-wide backing RAM after a programmable latency, then returns a single-cycle response echoing tag and opcode.
- Used as the memory model in simulation and FPGA bring-up, and as the template for the DRAM-controller front end.

Parameters:
- ADDR_W, 32: request address width (M_WIDTH).
- CL_BITS, 128: cache-line data width in bits (16 B lines).
- LG_CL_BYTES, 4: log2 of line bytes. Must equal log2(CL_BITS/8).
- TAG_W, 2: memory tag width (LG_MEM_TAG_ENTRIES).
- LG_LINES, 12: log2 of backing RAM depth in lines.
- LATENCY, 4: cycles spent in BUSY. Legal range 1..255.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous reset, active-low; state resets while reset==0.
- mem_req_valid  in  1  request pending. Level signal, held by the initiator until it sees mem_rsp_valid.
- mem_req_addr  in  ADDR_W  byte address of the line.
- mem_req_store_data  in  CL_BITS  write data for a store.
- mem_req_tag  in  TAG_W  request tag.
- mem_req_opcode  in  5  operation.
- mem_req_insn  in  1  request originates from the L1I.
- mem_req_ack  out  1  one-cycle pulse: request accepted.
- mem_rsp_valid  out  1  one-cycle pulse: response.
- mem_rsp_load_data  out  CL_BITS  line read data. Zero for stores and errors.
- mem_rsp_tag  out  TAG_W  echo of the accepted tag.
- mem_rsp_opcode  out  5  echo of the accepted opcode.
- busy  out  1  high from the cycle after acceptance through the RESP cycle.
- num_loads  out  32  count of completed line loads.
- num_stores  out  32  count of completed line stores.
- num_errors  out  32  count of rejected requests.

Behaviour:
- Reset (reset==0):
  - State goes to IDLE; all outputs and counters go to 0; latched request registers are cleared.
  - RAM contents are not cleared. Reset asserted mid-operation abandons the request and issues no response.
- State machine IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If mem_req_valid, latch addr/data/tag/opcode/insn, load lat_cnt = LATENCY-1 and go to BUSY.
  - mem_req_ack=1 in the next cycle only (registered pulse, coincides with the first BUSY cycle).
- BUSY:
  - lat_cnt decrements each cycle; mem_req_valid and the request inputs are ignored.
  - When lat_cnt==0, perform the access on the RAM and go to RESP.
- RESP:
  - mem_rsp_valid=1 for exactly one cycle; tag/opcode carry the latched values; load_data is held valid that cycle.
  - Next state is IDLE.
- Timing: request accepted at cycle T -> ack at T+1 -> response at T+LATENCY+1. Minimum spacing between acceptances is LATENCY+2 cycles.
- The initiator drops valid combinationally in the response cycle. A valid seen in the IDLE cycle after RESP is a new request and is accepted.
- RAM index = addr[LG_CL_BYTES +: LG_LINES]. Offset bits are ignored. Upper bits alias (no range fault).
- Opcodes:
  - MEM_LD_LINE: read the line; num_loads+1 at RESP.
  - MEM_ST_LINE: write the full line; load_data=0; num_stores+1 at RESP.
  - Any other opcode, or MEM_ST_LINE with insn=1: no RAM access; load_data=0; response still issued with the echo; num_errors+1.
- RAM read has 1-cycle latency. The read is issued in the cycle lat_cnt==1, or in the acceptance cycle when LATENCY==1, so data lands at RESP.
- A store followed by a load to the same line returns the new data (accesses are serialised).
- Counters wrap at 2^32.
- ack and rsp are never asserted in the same cycle.

Decomposition:
- Package mem_rsp_pkg holds:
  - opcode localparams MEM_LD_LINE=5'd4, MEM_ST_LINE=5'd7, shared with the L1D/L1I;
  - state enum state_t {IDLE, BUSY, RESP};
  - a request struct (addr, data, tag, opcode, insn).
- One sub-module, mem_line_ram: single-port synchronous RAM, CL_BITS wide, 2^LG_LINES deep, 1-cycle registered read, write-enable port.

Test Plan:
- Reset/idle: reset=0 for 3 cycles, then 1, with no valid -> all outputs 0 and busy=0 for 20 cycles.
- Store/load round trip: store addr 0x1000, tag 1, data 0xDEADBEEF_... (128 b), LATENCY=4, accepted at T -> ack at T+1, rsp at T+5 with tag 1, opcode 7, data 0. Then load 0x1008, tag 2 -> same data returned, tag 2, num_loads=1, num_stores=1.
- Back-to-back: initiator re-raises valid in the cycle after rsp (load, tag 3) -> accepted that cycle, ack one cycle later, no lost or duplicated response.
- Error: opcode 5'd9, tag 0 -> rsp at T+5, data 0, opcode 9 echoed, num_errors=1; insn=1 store -> error, RAM unchanged on readback.
- Mid-op reset: reset=0 at T+2 of a load -> no rsp, busy=0 next cycle; a subsequent load returns the previously stored RAM data.
- Aliasing/latency sweep: LATENCY=1 and 255; addr 0x1000 vs 0x1000+(1<<(LG_CL_BYTES+LG_LINES)) hit the same line; rsp exactly LATENCY+1 cycles after acceptance.
